instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the single-cycle core's instruction decode path.
- Generates sequential fetch addresses and issues req/gnt/rvalid transactions to instruction memory.
- Buffers returned instruction words, tagged with their PC, in a small FIFO and hands them to the core with a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes buffered and in-flight fetches.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-high
mem_req_o  out  1  fetch request to instruction memory
mem_addr_o  out  32  fetch byte address, valid while mem_req_o=1
mem_gnt_i  in  1  memory accepted request this cycle
mem_rvalid_i  in  1  read data valid (response to last granted request)
mem_rdata_i  in  32  instruction word
instr_valid_o  out  1  head entry valid
instr_o  out  32  head instruction
instr_pc_o  out  32  PC of head instruction
instr_ready_i  in  1  core consumes head when valid&ready
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  32  new fetch PC (sampled when redirect_i=1)
count_o  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, while rst_i=1):
  - mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, count_o=0.
  - fetch_pc=RESET_PC, state=IDLE, discard=0.
- Memory protocol:
  - At most one outstanding transaction.
  - mem_req_o and mem_addr_o are held stable until mem_gnt_i.
  - rvalid arrives >=1 cycle after gnt.
  - mem_rvalid_i is ignored outside WAIT.
- FSM states:
  - IDLE: if credit available (count + 0 < DEPTH), assert req with addr=fetch_pc and go to REQ in the same cycle (req is registered: asserted the cycle after entering IDLE with credit).
  - REQ: on gnt, latch req_addr=mem_addr_o, fetch_pc+=PC_STEP (mod 2^32), go to WAIT.
  - WAIT: on rvalid, push {req_addr, rdata} unless discard=1, clear discard, go to IDLE.
- Credit:
  - A request is issued only if occupancy + outstanding < DEPTH, so a push never overflows.
  - mem_req_o drops when the FIFO is full.
- Latency:
  - Without the optional feature, rvalid in cycle N gives instr_valid_o in cycle N+1.
  - Back-to-back throughput is one instruction per 3 cycles at minimum memory latency (IDLE->REQ->WAIT).
- FIFO:
  - Pop on instr_valid_o & instr_ready_i.
  - Simultaneous push and pop keeps occupancy constant.
  - Read/write pointers wrap modulo DEPTH.
  - Outputs reflect the head entry combinationally from storage; instr_o/instr_pc_o are 0 when empty.
- Redirect (redirect_i=1 in cycle N):
  - Next cycle: FIFO empty, count_o=0, fetch_pc=redirect_pc_i.
  - Any pop in cycle N is irrelevant (flush wins).
  - In REQ not yet granted: request stays asserted with the old address until gnt; discard=1; fetch_pc is still overwritten to redirect_pc_i (gnt does not increment it).
  - In WAIT: discard=1, and the matching rvalid is dropped.
  - Redirect in the same cycle as rvalid: that data is dropped.
  - Redirect in IDLE: next request uses redirect_pc_i.
  - Repeated redirects: the last one wins.
- Reset mid-transaction: all state is dropped immediately. Memory is reset by the same rst_i, so no stale response is expected, and any rvalid in IDLE is ignored.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a non-discarded rvalid arrives, instr_valid_o/instr_o/instr_pc_o present it in the same cycle.
  - If instr_ready_i=1 it is not written into the FIFO.
  - Latency is 0 cycles.
- Undefined: latency is always 1 cycle via the FIFO.

Decomposition:
- Package ifq_pkg holds:
  - state enum {IDLE, REQ, WAIT}
  - constant PC_STEP_DEF=4
  - RESET_PC_DEF
  - typedef ifq_entry_t {pc[31:0], instr[31:0]}
- One sub-module, ifq_fifo:
  - Parameterised synchronous FIFO of ifq_entry_t with push, pop, flush, full, empty and count.
  - Asynchronous active-high reset.

Test Plan:
- Reset then memory with 1-cycle rvalid and instr_ready_i=1, memory returning addr^32'hFFFF_FFFF -> instructions with PCs 0,4,8,12 in order, instr_o matching; mem_req_o never overlaps an outstanding request.
- instr_ready_i=0 with DEPTH=4 -> exactly 4 entries (PC 0..12), count_o=4, mem_req_o=0 thereafter; one pop -> count_o=3, then one new request at PC 16.
- Redirect to 32'h100 while in WAIT for PC 8 -> response for 8 dropped, count_o=0 next cycle, next fetch PC 32'h100 then 32'h104.
- Redirect to 32'h200 while REQ stalled (gnt low 3 cycles) at PC 4 -> address 4 held until gnt, its data discarded, next request 32'h200.
- Redirect coinciding with rvalid and a pop -> FIFO empty next cycle, no entry from that rvalid.
- rst_i asserted mid-WAIT with 2 entries buffered -> all outputs at reset values asynchronously; after release the first fetch is at RESET_PC; under IFQ_BYPASS_EN the first instr_valid_o is in the rvalid cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} ifq_state_e;

  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of PC-tagged instruction words with flush and occupancy count.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ifq_entry_t               data_i,
  input  logic                     pop_i,
  output ifq_entry_t               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  ifq_entry_t      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = count_q[PtrW];
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is fine when a pop frees the head slot this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with one outstanding req/gnt/rvalid transaction and a tagged
// FIFO. Define IFQ_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            instr_pc_o,
  input  logic                   instr_ready_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [$clog2(DEPTH):0] count_o
);

  ifq_state_e  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;
  logic        rsp_ok;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  ifq_entry_t  fifo_head, rsp_entry, head;

  assign rsp_entry = '{pc: req_addr_q, instr: mem_rdata_i};

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    rsp_ok     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Nothing is outstanding here, so occupancy alone decides credit; a redirect empties
        // the FIFO, which always leaves room.
        if (redirect_i || !fifo_full) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_i ? redirect_pc_i : fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_i) discard_d = 1'b1;
        if (mem_gnt_i) begin
          state_d    = WAIT;
          mem_req_d  = 1'b0;
          req_addr_d = mem_addr_q;
          if (!discard_q && !redirect_i) fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          rsp_ok    = !discard_q && !redirect_i;
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (redirect_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) fetch_pc_d = redirect_pc_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

`ifdef IFQ_BYPASS_EN
  // An accepted bypass word never enters the FIFO.
  assign fifo_push     = rsp_ok && !(fifo_empty && instr_ready_i);
  assign instr_valid_o = !fifo_empty || rsp_ok;
  assign head          = fifo_empty ? rsp_entry : fifo_head;
`else
  assign fifo_push     = rsp_ok;
  assign instr_valid_o = !fifo_empty;
  assign head          = fifo_head;
`endif

  assign fifo_pop   = !fifo_empty && instr_ready_i;
  assign instr_o    = instr_valid_o ? head.instr : '0;
  assign instr_pc_o = instr_valid_o ? head.pc : '0;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .data_i  (rsp_entry),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed table-driven bench for instr_fetch_queue (DEPTH=4, RESET_PC=0, PC_STEP=4).
module tb_instr_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [2:0]  count_o;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ready, gnt, rvalid, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t        tbl[$];
  int          nvec = 0;
  int          nfail = 0;
  logic [31:0] gnt_addr = '0;

  function automatic void add(bit r, bit g, bit rv, bit d, logic [31:0] rpc, bit req,
                              logic [31:0] addr, bit val, logic [31:0] pc, int cnt);
    vec_t v;
    v.ready = r; v.gnt = g; v.rvalid = rv; v.redir = d; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = val; v.pc = pc; v.cnt = 3'(cnt);
    tbl.push_back(v);
  endfunction

  // Memory answers with the complement of the granted address.
  task automatic apply(input vec_t v, input string name, input int idx);
    logic [31:0] exp_instr;
    instr_ready_i = v.ready;
    mem_gnt_i     = v.gnt;
    mem_rvalid_i  = v.rvalid;
    mem_rdata_i   = v.rvalid ? ~gnt_addr : 32'h0;
    redirect_i    = v.redir;
    redirect_pc_i = v.rpc;
    #2;
    exp_instr = v.valid ? ~v.pc : 32'h0;
    nvec++;
    if ({mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o} !==
        {v.req, v.addr, v.valid, exp_instr, v.pc, v.cnt}) begin
      nfail++;
      $display("FAIL %s[%0d]: got req=%0b addr=%h valid=%0b instr=%h pc=%h count=%0d",
               name, idx, mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o);
      $display("     %s[%0d]: want req=%0b addr=%h valid=%0b instr=%h pc=%h count=%0d",
               name, idx, v.req, v.addr, v.valid, exp_instr, v.pc, v.cnt);
    end
    if (v.gnt) gnt_addr = v.addr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input string name);
    foreach (tbl[i]) apply(tbl[i], name, i);
    tbl.delete();
    instr_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; redirect_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    instr_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; redirect_i = 1'b0;
    gnt_addr = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // ready=0: buffer PC 0 and 4, finish with the grant for PC 8.
  function automatic void prefix_fill();
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, Byp, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 4, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 4, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 4, 1, 0, 2);
    add(0, 1, 0, 0, 0, 1, 8, 1, 0, 2);
  endfunction

  initial begin
    do_reset();

`ifndef IFQ_BYPASS_EN
    // Streaming with ready=1: one instruction per three cycles, one cycle after rvalid.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'(4 * k);
      if (k == 0) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else        add(1, 0, 0, 0, 0, 0, a - 4, 1, a - 4, 1);
      add(1, 1, 0, 0, 0, 1, a, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0, a, 0, 0, 0);
    end
    add(1, 0, 0, 0, 0, 0, 12, 1, 12, 1);
    run("stream");
`else
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 4, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 4, 1, 4, 0);
    add(1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    run("bypass");
`endif

    // Fill to DEPTH with ready=0, then one pop lets exactly one new fetch out.
    do_reset();
    prefix_fill();
    add(0, 0, 1, 0, 0, 0, 8, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 8, 1, 0, 3);
    add(0, 1, 0, 0, 0, 1, 12, 1, 0, 3);
    add(0, 0, 1, 0, 0, 0, 12, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 12, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 12, 1, 0, 4);
    add(1, 0, 0, 0, 0, 0, 12, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 12, 1, 4, 3);
    add(0, 1, 0, 0, 0, 1, 16, 1, 4, 3);
    add(0, 0, 1, 0, 0, 0, 16, 1, 4, 3);
    add(0, 0, 0, 0, 0, 0, 16, 1, 4, 4);
    run("full");

    // Redirect while waiting for PC 8.
    do_reset();
    prefix_fill();
    add(0, 0, 0, 1, 32'h100, 0, 8, 1, 0, 2);
    add(0, 0, 1, 0, 0, 0, 8, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 32'h100, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 32'h100, Byp, Byp ? 32'h100 : 32'h0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h100, 1);
    add(0, 0, 0, 0, 0, 1, 32'h104, 1, 32'h100, 1);
    run("redir_wait");

`ifndef IFQ_BYPASS_EN
    // Redirect while the request for PC 4 is stalled without grant.
    do_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 32'h200, 1, 4, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 4, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 4, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 32'h200, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 32'h200, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h200, 1, 32'h200, 1);
    run("redir_req");
`endif

    // Redirect coinciding with rvalid and a pop.
    do_reset();
    prefix_fill();
    add(1, 0, 1, 1, 32'h300, 0, 8, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 8, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
    run("redir_rvalid");

    // Asynchronous reset mid-WAIT with two entries buffered.
    do_reset();
    prefix_fill();
    run("pre_rst");
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    rst_i        = 1'b1;
    #1;
    nvec++;
    if ({mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o} !== 101'b0) begin
      nfail++;
      $display("FAIL async_rst: got req=%0b addr=%h valid=%0b instr=%h pc=%h count=%0d, want 0",
               mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o);
    end
    @(posedge clk_i);
    #1;
    mem_rvalid_i = 1'b0;
    gnt_addr     = '0;
    rst_i        = 1'b0;
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, Byp, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    run("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
